// File: rtl/npu_f2i_pkg.sv
// -----------------------------------------------------------------------------
// npu_f2i_pkg
// Shared constants for the fixed-point to integer streaming converter.
//   DIN_W_DEF / DOUT_W_DEF / CNT_W_DEF : default widths of the top-level block
//   SHIFT_W                            : width of the shift-amount field
//   SHIFT_MAX                          : largest legal shift, also the number
//                                        of guard bits added to the product
//   SAT_POS_MSB / SAT_NEG_MSB          : saturation patterns, MSB-aligned in
//                                        SAT_MAX_W bits; a DOUT_W-wide value
//                                        is the top DOUT_W bits of each
// -----------------------------------------------------------------------------
package npu_f2i_pkg;

  localparam int DIN_W_DEF  = 16;
  localparam int DOUT_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  localparam int SHIFT_W   = 5;
  localparam int SHIFT_MAX = (1 << SHIFT_W) - 1;

  // MSB-aligned so that slicing [SAT_MAX_W-1 -: DOUT_W] yields the most
  // positive / most negative DOUT_W-bit two's-complement value.
  localparam int                   SAT_MAX_W   = 64;
  localparam logic [SAT_MAX_W-1:0] SAT_POS_MSB = {1'b0, {(SAT_MAX_W-1){1'b1}}};
  localparam logic [SAT_MAX_W-1:0] SAT_NEG_MSB = {1'b1, {(SAT_MAX_W-1){1'b0}}};

endpackage

// File: rtl/npu_f2i_shift.sv
// -----------------------------------------------------------------------------
// npu_f2i_shift
// Combinational shift-and-range-check between the two pipeline stages.
// The signed input is sign-extended to DIN_W+SHIFT_MAX bits and shifted left,
// so the full product is always exact; overflow means the bits from the
// output sign position upwards are not a pure sign extension.
//
// Build option: define NPU_F2I_SATURATE_EN to clamp overflowed results to the
// most positive / most negative DOUT_W value; otherwise the low DOUT_W bits
// are passed through (wrap).
//
// Ports
//   datain    in  DIN_W    signed fixed-point word
//   shiftupby in  SHIFT_W  left-shift amount
//   result    out DOUT_W   converted integer
//   ovf       out 1        product does not fit in DOUT_W signed
// -----------------------------------------------------------------------------
module npu_f2i_shift
  import npu_f2i_pkg::*;
#(
  parameter int DIN_W  = DIN_W_DEF,
  parameter int DOUT_W = DOUT_W_DEF
) (
  input  logic [DIN_W-1:0]   datain,
  input  logic [SHIFT_W-1:0] shiftupby,
  output logic [DOUT_W-1:0]  result,
  output logic               ovf
);

  localparam int PROD_W = DIN_W + SHIFT_MAX;
  // Bits from the output sign position up to the product MSB.
  localparam int TOP_W  = PROD_W - DOUT_W + 1;

`ifdef NPU_F2I_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic [PROD_W-1:0] ext;
  logic [PROD_W-1:0] product;
  logic [TOP_W-1:0]  top_bits;
  logic [DOUT_W-1:0] sat_value;

  always_comb begin
    ext      = {{SHIFT_MAX{datain[DIN_W-1]}}, datain};
    product  = ext << shiftupby;
    top_bits = product[PROD_W-1:DOUT_W-1];
    // In range only when the top bits are all zeros or all ones.
    ovf      = !((&top_bits) || !(|top_bits));
    // Product MSB is the true sign of the exact result.
    sat_value = product[PROD_W-1] ? SAT_NEG_MSB[SAT_MAX_W-1 -: DOUT_W]
                                  : SAT_POS_MSB[SAT_MAX_W-1 -: DOUT_W];
    result    = (ovf && SAT_EN) ? sat_value : product[DOUT_W-1:0];
  end

endmodule

// File: rtl/npu_fixed2int_stream.sv
// -----------------------------------------------------------------------------
// npu_fixed2int_stream
// Two-stage valid/ready pipeline converting a signed fixed-point word to a
// signed integer by a per-word left shift, with overflow flag and a saturating
// count of delivered overflowed results.
//   S1 : registers datain / shiftupby
//   S2 : registers shifted result and overflow flag (drives the outputs)
//
// Build option: NPU_F2I_SATURATE_EN (see npu_f2i_shift) selects saturating
// instead of wrapping results on overflow. Flag and counter are unaffected.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   npu_f2i_in_valid    in   input word present
//   npu_f2i_in_ready    out  input accepted this cycle when valid
//   npu_f2i_datain      in   DIN_W signed fixed-point word
//   npu_f2i_shiftupby   in   5-bit shift amount, sampled with the word
//   npu_f2i_out_valid   out  result present
//   npu_f2i_out_ready   in   consumer accepts result
//   npu_f2i_dataout     out  DOUT_W converted integer
//   npu_f2i_ovf         out  result overflowed (qualified by out_valid)
//   npu_f2i_clr_count   in   synchronous clear of ovf_count (wins over +1)
//   npu_f2i_ovf_count   out  CNT_W saturating count of delivered overflows
// -----------------------------------------------------------------------------
module npu_fixed2int_stream
  import npu_f2i_pkg::*;
#(
  parameter int DIN_W  = DIN_W_DEF,
  parameter int DOUT_W = DOUT_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               npu_f2i_in_valid,
  output logic               npu_f2i_in_ready,
  input  logic [DIN_W-1:0]   npu_f2i_datain,
  input  logic [SHIFT_W-1:0] npu_f2i_shiftupby,
  output logic               npu_f2i_out_valid,
  input  logic               npu_f2i_out_ready,
  output logic [DOUT_W-1:0]  npu_f2i_dataout,
  output logic               npu_f2i_ovf,
  input  logic               npu_f2i_clr_count,
  output logic [CNT_W-1:0]   npu_f2i_ovf_count
);

  logic               ready_en_reg;
  logic               s1_valid_reg;
  logic [DIN_W-1:0]   s1_data_reg;
  logic [SHIFT_W-1:0] s1_shift_reg;
  logic               s2_valid_reg;
  logic [DOUT_W-1:0]  s2_data_reg;
  logic               s2_ovf_reg;
  logic [CNT_W-1:0]   ovf_count_reg;

  logic               s1_advance;
  logic               in_fire;
  logic               out_fire;
  logic [DOUT_W-1:0]  shift_result;
  logic               shift_ovf;

  // S2 can take a new word when it is empty or its word leaves this cycle.
  assign s1_advance       = !s2_valid_reg || npu_f2i_out_ready;
  // ready_en_reg keeps in_ready low while in reset and for nothing longer
  // than the first edge after release.
  assign npu_f2i_in_ready = ready_en_reg && (!s1_valid_reg || s1_advance);
  assign in_fire          = npu_f2i_in_valid && npu_f2i_in_ready;
  assign out_fire         = s2_valid_reg && npu_f2i_out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
    end
  end

  // Stage 1: capture input word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_shift_reg <= '0;
    end else begin
      if (npu_f2i_in_ready) begin
        s1_valid_reg <= in_fire;
      end
      if (in_fire) begin
        s1_data_reg  <= npu_f2i_datain;
        s1_shift_reg <= npu_f2i_shiftupby;
      end
    end
  end

  npu_f2i_shift #(
    .DIN_W  (DIN_W),
    .DOUT_W (DOUT_W)
  ) u_shift (
    .datain    (s1_data_reg),
    .shiftupby (s1_shift_reg),
    .result    (shift_result),
    .ovf       (shift_ovf)
  );

  // Stage 2: hold result until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_data_reg  <= '0;
      s2_ovf_reg   <= 1'b0;
    end else if (s1_advance) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_data_reg <= shift_result;
        s2_ovf_reg  <= shift_ovf;
      end
    end
  end

  // Saturating count of overflowed results actually delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count_reg <= '0;
    end else if (npu_f2i_clr_count) begin
      ovf_count_reg <= '0;
    end else if (out_fire && s2_ovf_reg && !(&ovf_count_reg)) begin
      ovf_count_reg <= ovf_count_reg + 1'b1;
    end
  end

  assign npu_f2i_out_valid = s2_valid_reg;
  assign npu_f2i_dataout   = s2_data_reg;
  assign npu_f2i_ovf       = s2_valid_reg && s2_ovf_reg;
  assign npu_f2i_ovf_count = ovf_count_reg;

endmodule

// File: tb/tb_npu_fixed2int_stream.sv
// -----------------------------------------------------------------------------
// tb_npu_fixed2int_stream
// Self-checking bench for npu_fixed2int_stream. Expected results come from an
// arithmetic reference model (exact product in a 64-bit integer, range-checked
// against the DOUT_W signed limits) and a scoreboard queue of words in flight.
// Define NPU_F2I_SATURATE_EN for both bench and RTL to check the saturating
// build.
// -----------------------------------------------------------------------------
module tb_npu_fixed2int_stream;

  localparam int DIN_W  = 16;
  localparam int DOUT_W = 32;
  localparam int CNT_W  = 16;

`ifdef NPU_F2I_SATURATE_EN
  localparam bit SAT_BUILD = 1'b1;
`else
  localparam bit SAT_BUILD = 1'b0;
`endif

  typedef struct packed {
    logic [DOUT_W-1:0] data;
    logic              ovf;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DIN_W-1:0]  datain;
  logic [4:0]        shiftupby;
  logic              out_valid;
  logic              out_ready;
  logic [DOUT_W-1:0] dataout;
  logic              ovf;
  logic              clr_count;
  logic [CNT_W-1:0]  ovf_count;

  int         n_tests = 0;
  int         n_fail  = 0;
  exp_t       exp_q[$];
  logic [CNT_W-1:0] model_cnt;

  always #5 clk = ~clk;

  npu_fixed2int_stream #(
    .DIN_W  (DIN_W),
    .DOUT_W (DOUT_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .npu_f2i_in_valid  (in_valid),
    .npu_f2i_in_ready  (in_ready),
    .npu_f2i_datain    (datain),
    .npu_f2i_shiftupby (shiftupby),
    .npu_f2i_out_valid (out_valid),
    .npu_f2i_out_ready (out_ready),
    .npu_f2i_dataout   (dataout),
    .npu_f2i_ovf       (ovf),
    .npu_f2i_clr_count (clr_count),
    .npu_f2i_ovf_count (ovf_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Exact arithmetic: value = datain * 2^shift, then range test.
  function automatic exp_t model(input logic [DIN_W-1:0] d, input logic [4:0] sh);
    exp_t   r;
    longint v;
    v     = longint'($signed(d)) * (longint'(1) << sh);
    r.ovf = (v > 64'sd2147483647) || (v < -64'sd2147483648);
    if (r.ovf && SAT_BUILD)
      r.data = (v < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else
      r.data = 32'(v);
    return r;
  endfunction

  // One clock cycle: drive at the falling edge, sample 1 ns later, score
  // transfers that will happen on the next rising edge.
  task automatic step(input logic iv, input logic [DIN_W-1:0] d, input logic [4:0] sh,
                      input logic orr, input logic clr, input exp_t e,
                      output bit acc, output bit fired);
    exp_t g;
    g = '0;
    @(negedge clk);
    in_valid  = iv;
    datain    = d;
    shiftupby = sh;
    out_ready = orr;
    clr_count = clr;
    #1;
    check("ovf_count", ovf_count, model_cnt);
    fired = out_valid && out_ready;
    acc   = in_valid && in_ready;
    if (fired) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 1, 0);
      end else begin
        g = exp_q.pop_front();
        check("dataout", dataout, g.data);
        check("ovf", ovf, g.ovf);
        $display("[TB] out dataout=0x%08h ovf=%0b", dataout, ovf);
      end
    end
    if (acc) exp_q.push_back(e);
    if (clr) model_cnt = '0;
    else if (fired && g.ovf && model_cnt != '1) model_cnt = model_cnt + 1'b1;
  endtask

  task automatic drain(output int cycles);
    exp_t z;
    bit   a, f;
    int   n;
    z = '0;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step(1'b0, '0, '0, 1'b1, 1'b0, z, a, f);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    cycles = n;
  endtask

  task automatic directed(input string tag, input logic [DIN_W-1:0] d, input logic [4:0] sh,
                          input logic [DOUT_W-1:0] ed, input logic eo);
    exp_t e;
    bit   a, f;
    int   n, lat;
    e.data = ed;
    e.ovf  = eo;
    a = 1'b0;
    n = 0;
    while (!a && n < 10) begin
      step(1'b1, d, sh, 1'b1, 1'b0, e, a, f);
      n++;
    end
    check({tag, "_accepted"}, a, 1);
    drain(lat);
    check({tag, "_latency"}, lat, 2);
  endtask

  logic [DIN_W-1:0] bp_d[3];
  logic [4:0]       bp_s[3];

  initial begin
    exp_t        z, e;
    bit          a, f;
    int          n, k, fires;
    logic [DOUT_W-1:0] held;

    z = '0;
    rst_n = 1'b0; in_valid = 1'b0; datain = '0; shiftupby = '0;
    out_ready = 1'b0; clr_count = 1'b0; model_cnt = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_dataout", dataout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_ovf_count", ovf_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("in_ready_after_reset", in_ready, 1);

    // Directed conversions
    directed("c53a_s0", 16'hC53A, 5'd0, 32'hFFFF_C53A, 1'b0);
    directed("c53a_s4", 16'hC53A, 5'd4, 32'hFFFC_53A0, 1'b0);
    directed("7fff_s16", 16'h7FFF, 5'd16, 32'h7FFF_0000, 1'b0);
    directed("7fff_s17", 16'h7FFF, 5'd17, SAT_BUILD ? 32'h7FFF_FFFF : 32'hFFFE_0000, 1'b1);
    directed("ffff_s31", 16'hFFFF, 5'd31, 32'h8000_0000, 1'b0);
    directed("0001_s31", 16'h0001, 5'd31, SAT_BUILD ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b1);
    directed("8000_s31", 16'h8000, 5'd31, SAT_BUILD ? 32'h8000_0000 : 32'h0000_0000, 1'b1);

    // Backpressure: consumer stalled for 5 cycles while 3 words are offered
    for (int i = 0; i < 3; i++) begin
      bp_d[i] = DIN_W'($urandom);
      bp_s[i] = 5'($urandom_range(0, 8));
    end
    k = 0;
    held = '0;
    for (int i = 0; i < 5; i++) begin
      e = model(bp_d[k], bp_s[k]);
      step(1'b1, bp_d[k], bp_s[k], 1'b0, 1'b0, e, a, f);
      if (a) k++;
      if (i == 2) held = dataout;
      if (i >= 2) begin
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
      end
      if (i >= 3) check("bp_hold", dataout, held);
    end
    e = model(bp_d[0], bp_s[0]);
    check("bp_head", dataout, e.data);
    check("bp_accepted", k, 2);
    n = 0;
    while (k < 3 && n < 10) begin
      e = model(bp_d[k], bp_s[k]);
      step(1'b1, bp_d[k], bp_s[k], 1'b1, 1'b0, e, a, f);
      if (a) k++;
      n++;
    end
    check("bp_third_accepted", k, 3);
    drain(n);

    // Overflow counter: clear, then 3 overflowed deliveries, clear on the 3rd
    step(1'b0, '0, '0, 1'b0, 1'b1, z, a, f);
    for (int j = 0; j < 3; j++) begin
      e = model(16'h0001, 5'd31);
      a = 1'b0;
      n = 0;
      while (!a && n < 10) begin
        step(1'b1, 16'h0001, 5'd31, 1'b0, 1'b0, e, a, f);
        n++;
      end
      n = 0;
      step(1'b0, '0, '0, 1'b0, 1'b0, z, a, f);
      while (!out_valid && n < 10) begin
        step(1'b0, '0, '0, 1'b0, 1'b0, z, a, f);
        n++;
      end
      check("cnt_out_valid", out_valid, 1);
      step(1'b0, '0, '0, 1'b1, (j == 2), z, a, f);
      check("cnt_delivered", f, 1);
      step(1'b0, '0, '0, 1'b0, 1'b0, z, a, f);
      check("cnt_value", ovf_count, (j == 2) ? 0 : j + 1);
    end

    // Randomized streaming against the model
    for (int i = 0; i < 500; i++) begin
      logic [DIN_W-1:0] rd;
      logic [4:0]       rs;
      rd = DIN_W'($urandom);
      if ($urandom_range(0, 3) == 0) rd = DIN_W'($urandom_range(0, 255)) - DIN_W'(128);
      rs = 5'($urandom_range(0, 31));
      e  = model(rd, rs);
      step(($urandom_range(0, 3) != 0), rd, rs, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 49) == 0), e, a, f);
    end
    drain(n);

    // Reset with two words in flight
    k = 0;
    n = 0;
    while (k < 2 && n < 10) begin
      rand_word: begin
        logic [DIN_W-1:0] rd;
        rd = DIN_W'($urandom);
        e  = model(rd, 5'd3);
        step(1'b1, rd, 5'd3, 1'b0, 1'b0, e, a, f);
        if (a) k++;
      end
      n++;
    end
    check("rst2_loaded", k, 2);
    @(negedge clk);
    #1;
    check("rst2_pre_valid", out_valid, 1);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst2_out_valid", out_valid, 0);
    check("rst2_in_ready", in_ready, 0);
    check("rst2_ovf_count", ovf_count, 0);
    exp_q.delete();
    model_cnt = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fires = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, '0, 1'b1, 1'b0, z, a, f);
      if (out_valid) fires++;
    end
    check("rst2_no_stale", fires, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
